// File: rtl/apb_master.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module  : apb_master
// | Purpose : Single-request APB master with two slave selects, registered
// |           outputs and an optional ACCESS-phase timeout (APB_TIMEOUT_EN).
// | Revision: 1.0 - initial release
// +----------------------------------------------------------------------------
module apb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       PCLK,
  input  logic       PRST,
  input  logic       transfer,
  input  logic       rw,
  input  logic [8:0] apb_addr,
  input  logic [7:0] apb_wdata,
  input  logic       PREADY,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  output logic [7:0] rdata_out,
  output logic       done,
  output logic       busy,
  output logic       error
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t r_state;

  logic       w_complete;
  logic       w_launch;
  logic       w_tmo_hit;
  logic [7:0] w_rdata;

  assign w_complete = (r_state == S_ACCESS) && PREADY;
  // A new request is only accepted from IDLE or on the completion edge.
  assign w_launch   = transfer && ((r_state == S_IDLE) || w_complete);
  assign w_rdata    = PSEL2 ? PRDATA2 : PRDATA1;

`ifdef APB_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_CNT_W-1:0] r_tmo_cnt;
  logic               r_error;

  assign w_tmo_hit = (r_tmo_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
  assign error     = r_error;

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      r_tmo_cnt <= '0;
      r_error   <= 1'b0;
    end else begin
      r_error <= 1'b0;
      if (w_launch) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == S_ACCESS) && !PREADY) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
        r_error   <= w_tmo_hit;
      end
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  // Constant zero; the comparison keeps the parameter referenced in this build.
  assign error     = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      r_state   <= S_IDLE;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= 8'h00;
      PWDATA    <= 8'h00;
      rdata_out <= 8'h00;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;

      case (r_state)
        S_SETUP: begin
          r_state <= S_ACCESS;
          PENABLE <= 1'b1;
        end
        S_ACCESS: begin
          if (PREADY || w_tmo_hit) begin
            if (PREADY) begin
              done <= 1'b1;
              if (!PWRITE) begin
                rdata_out <= w_rdata;
              end
            end
            r_state <= S_IDLE;
            PSEL1   <= 1'b0;
            PSEL2   <= 1'b0;
            PENABLE <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // The launch overrides the return-to-IDLE values above for back-to-back.
      if (w_launch) begin
        r_state <= S_SETUP;
        PSEL1   <= ~apb_addr[8];
        PSEL2   <= apb_addr[8];
        PENABLE <= 1'b0;
        PWRITE  <= rw;
        PADDR   <= apb_addr[7:0];
        PWDATA  <= apb_wdata;
        busy    <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// Randomized scoreboard bench for apb_master: two memory-backed slaves with
// random wait states, a transaction-level reference model and a cycle monitor.
module tb_apb_master;

  localparam int TMO = 4;

  logic       PCLK = 1'b0;
  logic       PRST = 1'b1;
  logic       transfer = 1'b0;
  logic       rw = 1'b0;
  logic [8:0] apb_addr = 9'h000;
  logic [7:0] apb_wdata = 8'h00;
  logic       PREADY = 1'b0;
  logic [7:0] PRDATA1;
  logic [7:0] PRDATA2;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, rdata_out;
  logic       done, busy, error;

  apb_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .PCLK      (PCLK),
    .PRST      (PRST),
    .transfer  (transfer),
    .rw        (rw),
    .apb_addr  (apb_addr),
    .apb_wdata (apb_wdata),
    .PREADY    (PREADY),
    .PRDATA1   (PRDATA1),
    .PRDATA2   (PRDATA2),
    .PSEL1     (PSEL1),
    .PSEL2     (PSEL2),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .rdata_out (rdata_out),
    .done      (done),
    .busy      (busy),
    .error     (error)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slaves ----------------
  logic [7:0] mem [2][256];
  int acc_cnt     = 0;
  int cur_waits   = 0;
  int force_waits = -1;

  assign PRDATA1 = mem[0][PADDR];
  assign PRDATA2 = mem[1][PADDR];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[0][i] = 8'(i * 3 + 1);
      mem[1][i] = 8'(i ^ 8'h5A);
    end
  end

  // PREADY is noise outside ACCESS; inside ACCESS it rises after cur_waits cycles.
  always @(posedge PCLK) begin
    #1;
    if (PENABLE && (PSEL1 || PSEL2)) begin
      if (acc_cnt == 0) begin
        if (force_waits >= 0) cur_waits = force_waits;
        else if ($urandom_range(0, 4) == 0) cur_waits = 5;
        else cur_waits = $urandom_range(0, 2);
      end
      PREADY = (acc_cnt >= cur_waits);
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      PREADY  = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge PCLK) begin
    if (PENABLE && PREADY && PWRITE) begin
      if (PSEL1) mem[0][PADDR] = PWDATA;
      if (PSEL2) mem[1][PADDR] = PWDATA;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic       sel;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [7:0] old;
    logic       b2b;
  } item_t;

  item_t      q_exp[$];
  logic [7:0] rm [2][256];

  function automatic logic [18:0] exp_vec(input item_t it);
    return {~it.sel, it.sel, it.wr, it.addr, it.wdata};
  endfunction

  // ---------------- monitor ----------------
  logic        rst_edge = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_err  = 1'b0;
  logic [7:0]  last_rd  = 8'h00;
  int          post_chk = 0;
  int          acc_zero = 0;
  bit          have_prev = 0;
  logic [18:0] prev_vec, cur_vec;
  item_t       mon_it;
  int          n_done = 0;

  always @(posedge PCLK) rst_edge <= PRST;

  always @(negedge PCLK) begin
    if (rst_edge) begin
      chk("reset_values", 32'({PSEL1, PSEL2, PENABLE, PWRITE, done, busy, error,
                                PADDR, PWDATA, rdata_out}), 32'h0);
      while (q_exp.size() > 0) begin
        mon_it = q_exp.pop_back();
        if (mon_it.wr) rm[mon_it.sel][mon_it.addr] = mon_it.old;
      end
      exp_done  = 1'b0;
      exp_err   = 1'b0;
      last_rd   = 8'h00;
      post_chk  = 0;
      acc_zero  = 0;
      have_prev = 0;
    end else begin
      chk("done", 32'(done), 32'(exp_done));
      chk("error", 32'(error), 32'(exp_err));
      chk("rdata_out", 32'(rdata_out), 32'(last_rd));
      chk("psel_onehot", 32'(PSEL1 & PSEL2), 32'h0);
      chk("busy", 32'(busy), 32'(PSEL1 | PSEL2));
      if (post_chk == 1 && q_exp.size() > 0 && q_exp[0].b2b)
        chk("b2b_setup", 32'({PSEL1 | PSEL2, PENABLE}), 32'h2);
      else if (post_chk != 0)
        chk("return_idle", 32'({PSEL1, PSEL2, PENABLE, busy}), 32'h0);
      exp_done = 1'b0;
      exp_err  = 1'b0;
      post_chk = 0;
      cur_vec  = {PSEL1, PSEL2, PWRITE, PADDR, PWDATA};

      if ((PSEL1 || PSEL2) && !PENABLE) begin
        if (q_exp.size() == 0) chk("setup_has_request", 32'h0, 32'h1);
        else chk("setup_fields", 32'(cur_vec), 32'(exp_vec(q_exp[0])));
        acc_zero  = 0;
        have_prev = 0;
      end else if (PENABLE) begin
        if (have_prev) chk("access_stable", 32'(cur_vec), 32'(prev_vec));
        prev_vec  = cur_vec;
        have_prev = 1;
        if (PREADY) begin
          if (q_exp.size() == 0) begin
            chk("access_has_request", 32'h0, 32'h1);
          end else begin
            mon_it = q_exp.pop_front();
            chk("complete_fields", 32'(cur_vec), 32'(exp_vec(mon_it)));
            if (!mon_it.wr) last_rd = mon_it.rdata;
          end
          n_done++;
          exp_done  = 1'b1;
          post_chk  = 1;
          have_prev = 0;
          acc_zero  = 0;
        end else begin
          acc_zero++;
`ifdef APB_TIMEOUT_EN
          if (acc_zero == TMO) begin
            if (q_exp.size() > 0) begin
              mon_it = q_exp.pop_front();
              if (mon_it.wr) rm[mon_it.sel][mon_it.addr] = mon_it.old;
            end
            exp_err   = 1'b1;
            post_chk  = 2;
            have_prev = 0;
            acc_zero  = 0;
          end
`endif
        end
      end else begin
        have_prev = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input bit w, input logic [8:0] a, input logic [7:0] d);
    item_t it;
    int    guard = 0;
    forever begin
      @(negedge PCLK);
      if (!busy || (PENABLE && PREADY)) break;
      // Junk on the request inputs while busy must be ignored.
      transfer  = 1'($urandom_range(0, 1));
      rw        = 1'($urandom_range(0, 1));
      apb_addr  = 9'($urandom);
      apb_wdata = 8'($urandom);
      guard++;
      if (guard > 200) begin
        chk("send_wait_budget", 32'h0, 32'h1);
        transfer = 1'b0;
        return;
      end
    end
    transfer  = 1'b1;
    rw        = w;
    apb_addr  = a;
    apb_wdata = d;
    it.sel   = a[8];
    it.wr    = w;
    it.addr  = a[7:0];
    it.wdata = d;
    it.old   = rm[a[8]][a[7:0]];
    it.rdata = rm[a[8]][a[7:0]];
    it.b2b   = busy;
    if (w) rm[a[8]][a[7:0]] = d;
    q_exp.push_back(it);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge PCLK);
      transfer = 1'b0;
    end
  endtask

  task automatic do_reset_in_access();
    int guard = 0;
    forever begin
      @(negedge PCLK);
      transfer = 1'b0;
      if (PENABLE && !PREADY) break;
      guard++;
      if (guard > 50) begin
        chk("reset_wait_budget", 32'h0, 32'h1);
        return;
      end
    end
    PRST = 1'b1;
    @(negedge PCLK);
    PRST = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      rm[0][i] = 8'(i * 3 + 1);
      rm[1][i] = 8'(i ^ 8'h5A);
    end
    PRST = 1'b1;
    repeat (3) @(negedge PCLK);
    PRST = 1'b0;

    send(1'b1, 9'h012, 8'hA5);
    idle(3);
    send(1'b1, 9'h134, 8'h3C);
    idle(2);
    send(1'b0, 9'h134, 8'h00);
    idle(2);
    send(1'b1, 9'h001, 8'h5A);
    send(1'b0, 9'h001, 8'h00);
    idle(3);

    force_waits = 5;
    send(1'b1, 9'h0AA, 8'h77);
    idle(12);
    force_waits = -1;

    force_waits = 5;
    send(1'b1, 9'h1F0, 8'hEE);
    do_reset_in_access();
    force_waits = -1;
    idle(2);
    send(1'b0, 9'h1F0, 8'h00);
    idle(8);

`ifdef APB_TIMEOUT_EN
    force_waits = 20;
    send(1'b0, 9'h055, 8'h00);
    idle(12);
    force_waits = -1;
`endif

    for (int k = 0; k < 300; k++) begin
      send(1'($urandom_range(0, 1)),
           {1'($urandom_range(0, 1)), 4'h0, 4'($urandom_range(0, 15))},
           8'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(25);
    chk("queue_drained", 32'(q_exp.size()), 32'h0);
    chk("some_completions", 32'(n_done > 100), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
